// File: rtl/ram_data_mrw_pkg.sv
// ram_pkg: shared helpers for the multi-read data RAM.
// Address width, masked segment merge, read-result struct macro.
`ifndef RAM_RD_RES_T
`define RAM_RD_RES_T(W) struct packed { \
   logic valid; \
   logic [(W)-1:0] data; \
}
`endif

package ram_pkg;

   // Widest entry supported by the shared merge helper.
   localparam int MAX_W = 512;

   // clog2 with a floor of one bit.
   function automatic int addr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // Bit b comes from nw when its segment's mask bit is set.
   function automatic logic [MAX_W-1:0] seg_merge(
      input logic [MAX_W-1:0] old_d,
      input logic [MAX_W-1:0] nw_d,
      input logic [MAX_W-1:0] mask,
      input int               seg_w
   );
      logic [MAX_W-1:0] r;
      for (int b = 0; b < MAX_W; b++) begin
         r[b] = mask[b / seg_w] ? nw_d[b] : old_d[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_data_mrw_rdport.sv
// ram_mrw_rdport: one read port of ram_data_mrw.
// In: W0_clk, reset_n, r_en/r_addr, mem/valid, write-side bypass info.
// Out: r_data/r_valid, combinational or registered (READ_LAT).
`ifndef RAM_RD_RES_T
`define RAM_RD_RES_T(W) struct packed { \
   logic valid; \
   logic [(W)-1:0] data; \
}
`endif

module ram_mrw_rdport
   import ram_pkg::*;
#(
   parameter int DEPTH    = 5,
   parameter int WIDTH    = 65,
   parameter int AW       = 3,
   parameter int READ_LAT = 0,
   parameter int BYPASS   = 1
) (
   input  logic             W0_clk,
   input  logic             reset_n,
   input  logic             r_en,
   input  logic [AW-1:0]    r_addr,
   input  logic [WIDTH-1:0] mem [0:DEPTH-1],
   input  logic [DEPTH-1:0] valid,
   input  logic             wr_hit,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_merged,
   output logic [WIDTH-1:0] r_data,
   output logic             r_valid
);

   typedef `RAM_RD_RES_T(WIDTH) rd_res_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   rd_res_t res_c;
   logic    in_rng;
   logic    byp;
   logic    unused_byp;

   assign in_rng = ({1'b0, r_addr} < DEPTH_C);
   assign byp    = (BYPASS != 0) && wr_hit
                && (r_addr == wr_addr);

   // Consumed only when bypass is compiled out.
   assign unused_byp = ^{wr_hit, wr_addr, wr_merged};

   // Invalid, disabled or out-of-range reads are forced to zero.
   always_comb begin
      res_c = '0;
      if (r_en && in_rng) begin
         if (byp) begin
            res_c.valid = 1'b1;
            res_c.data  = wr_merged;
         end else if (valid[r_addr]) begin
            res_c.valid = 1'b1;
            res_c.data  = mem[r_addr];
         end
      end
   end

   if (READ_LAT == 0) begin : g_comb
      logic unused_clk;
      assign unused_clk = W0_clk ^ reset_n;
      assign r_data     = res_c.data;
      assign r_valid    = res_c.valid;
   end else begin : g_reg
      rd_res_t res_q;
      // Holds the last result while the port is idle.
      always_ff @(posedge W0_clk or negedge reset_n) begin
         if (!reset_n) begin
            res_q <= '0;
         end else if (r_en) begin
            res_q <= res_c;
         end
      end
      assign r_data  = res_q.data;
      assign r_valid = res_q.valid;
   end

endmodule

// File: rtl/ram_data_mrw.sv
// ram_data_mrw: DEPTH x WIDTH RAM, 1 masked write, NUM_READ reads,
// per-entry valid bits with async reset and sync flush.
// In: W0_clk, reset_n, flush, W0_en/addr/mask/data, R_en, R_addr.
// Out: R_data (NUM_READ*WIDTH), R_valid (NUM_READ).
module ram_data_mrw
   import ram_pkg::*;
#(
   parameter  int DEPTH    = 5,
   parameter  int WIDTH    = 65,
   parameter  int NUM_READ = 2,
   parameter  int SEG_W    = 13,
   parameter  int READ_LAT = 0,
   parameter  int BYPASS   = 1,
   localparam int AW       = addr_w(DEPTH),
   localparam int NSEG     = WIDTH / SEG_W
) (
   input  logic                      W0_clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      W0_en,
   input  logic [AW-1:0]             W0_addr,
   input  logic [NSEG-1:0]           W0_mask,
   input  logic [WIDTH-1:0]          W0_data,
   input  logic [NUM_READ-1:0]       R_en,
   input  logic [NUM_READ*AW-1:0]    R_addr,
   output logic [NUM_READ*WIDTH-1:0] R_data,
   output logic [NUM_READ-1:0]       R_valid
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] valid_nxt;
   logic             wr_hit;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] wr_merged;

   // Writes are ignored while reset is held so nothing
   // bypasses onto the outputs during reset.
   assign wr_hit = reset_n && W0_en
                && ({1'b0, W0_addr} < DEPTH_C);

   assign wr_old = wr_hit ? mem[W0_addr] : '0;

   assign wr_merged = WIDTH'(seg_merge(
      MAX_W'(wr_old), MAX_W'(W0_data),
      MAX_W'(W0_mask), SEG_W));

   always_ff @(posedge W0_clk) begin
      if (wr_hit) begin
         mem[W0_addr] <= wr_merged;
      end
   end

   // Flush first, then the write re-marks its entry.
   always_comb begin
      valid_nxt = valid;
      if (flush) begin
         valid_nxt = '0;
      end
      if (wr_hit) begin
         valid_nxt[W0_addr] = 1'b1;
      end
   end

   always_ff @(posedge W0_clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
      end else begin
         valid <= valid_nxt;
      end
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
      ram_mrw_rdport #(
         .DEPTH    (DEPTH),
         .WIDTH    (WIDTH),
         .AW       (AW),
         .READ_LAT (READ_LAT),
         .BYPASS   (BYPASS)
      ) u_rd (
         .W0_clk    (W0_clk),
         .reset_n   (reset_n),
         .r_en      (R_en[gi]),
         .r_addr    (R_addr[gi*AW +: AW]),
         .mem       (mem),
         .valid     (valid),
         .wr_hit    (wr_hit),
         .wr_addr   (W0_addr),
         .wr_merged (wr_merged),
         .r_data    (R_data[gi*WIDTH +: WIDTH]),
         .r_valid   (R_valid[gi])
      );
   end

endmodule

// File: tb/tb_ram_data_mrw.sv
// tb_ram_data_mrw: directed plus random checks of ram_data_mrw
// across latency, port count, bypass and depth variants.
`timescale 1ns/1ps
module tb_ram_data_mrw;

   localparam int NI = 5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        w_en;
   logic [2:0]  w_addr;
   logic [4:0]  w_mask;
   logic [64:0] w_data;
   logic [1:0]  r_en;
   logic [5:0]  r_addr;

   logic [129:0] d0, d1, d3;
   logic [64:0]  d2, d4;
   logic [1:0]   v0, v1, v3;
   logic         v2, v4;

   logic [64:0] od [NI][2];
   logic        ov [NI][2];

   logic [64:0] mm [NI][8];
   logic        mv [NI][8];
   logic [64:0] qd [NI][2];
   logic        qv [NI][2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_data_mrw #(.DEPTH(5), .NUM_READ(2),
      .READ_LAT(0), .BYPASS(1)) u0 (
      .W0_clk(clk), .reset_n(reset_n), .flush(flush),
      .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask),
      .W0_data(w_data), .R_en(r_en), .R_addr(r_addr),
      .R_data(d0), .R_valid(v0));

   ram_data_mrw #(.DEPTH(5), .NUM_READ(2),
      .READ_LAT(1), .BYPASS(1)) u1 (
      .W0_clk(clk), .reset_n(reset_n), .flush(flush),
      .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask),
      .W0_data(w_data), .R_en(r_en), .R_addr(r_addr),
      .R_data(d1), .R_valid(v1));

   ram_data_mrw #(.DEPTH(5), .NUM_READ(1),
      .READ_LAT(0), .BYPASS(0)) u2 (
      .W0_clk(clk), .reset_n(reset_n), .flush(flush),
      .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask),
      .W0_data(w_data), .R_en(r_en[0:0]),
      .R_addr(r_addr[2:0]),
      .R_data(d2), .R_valid(v2));

   ram_data_mrw #(.DEPTH(8), .NUM_READ(2),
      .READ_LAT(0), .BYPASS(1)) u3 (
      .W0_clk(clk), .reset_n(reset_n), .flush(flush),
      .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask),
      .W0_data(w_data), .R_en(r_en), .R_addr(r_addr),
      .R_data(d3), .R_valid(v3));

   ram_data_mrw #(.DEPTH(8), .NUM_READ(1),
      .READ_LAT(1), .BYPASS(0)) u4 (
      .W0_clk(clk), .reset_n(reset_n), .flush(flush),
      .W0_en(w_en), .W0_addr(w_addr), .W0_mask(w_mask),
      .W0_data(w_data), .R_en(r_en[0:0]),
      .R_addr(r_addr[2:0]),
      .R_data(d4), .R_valid(v4));

   assign od[0][0] = d0[64:0];
   assign od[0][1] = d0[129:65];
   assign od[1][0] = d1[64:0];
   assign od[1][1] = d1[129:65];
   assign od[2][0] = d2;
   assign od[2][1] = '0;
   assign od[3][0] = d3[64:0];
   assign od[3][1] = d3[129:65];
   assign od[4][0] = d4;
   assign od[4][1] = '0;
   assign ov[0][0] = v0[0];
   assign ov[0][1] = v0[1];
   assign ov[1][0] = v1[0];
   assign ov[1][1] = v1[1];
   assign ov[2][0] = v2;
   assign ov[2][1] = 1'b0;
   assign ov[3][0] = v3[0];
   assign ov[3][1] = v3[1];
   assign ov[4][0] = v4;
   assign ov[4][1] = 1'b0;

   function automatic int dep(input int k);
      return (k >= 3) ? 8 : 5;
   endfunction

   function automatic int nrd(input int k);
      return (k == 2 || k == 4) ? 1 : 2;
   endfunction

   function automatic bit lat(input int k);
      return (k == 1 || k == 4);
   endfunction

   function automatic bit byp(input int k);
      return (k == 0 || k == 1 || k == 3);
   endfunction

   // Entry after the current write: masked 13-bit granules replaced.
   function automatic logic [64:0] merged(input logic [64:0] o);
      logic [64:0] r;
      r = o;
      for (int s = 0; s < 5; s++) begin
         if (w_mask[s]) r[s*13 +: 13] = w_data[s*13 +: 13];
      end
      return r;
   endfunction

   // {valid, data} the read rules give for instance k right now.
   function automatic logic [65:0] exp_rd(
      input int k, input logic en, input logic [2:0] a);
      if (!en || int'(a) >= dep(k)) return '0;
      if (byp(k) && w_en && a == w_addr)
         return {1'b1, merged(mm[k][a])};
      if (mv[k][a]) return {1'b1, mm[k][a]};
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [64:0] d,
      input logic v, input logic [65:0] e);
      checks++;
      assert (v === e[65]) else begin
         errors++;
         $error("FAIL %s valid got %b exp %b", tag, v, e[65]);
      end
      checks++;
      assert (d === e[64:0]) else begin
         errors++;
         $error("FAIL %s data got %h exp %h", tag, d, e[64:0]);
      end
      checks++;
      assert (!$isunknown(d)) else begin
         errors++;
         $error("FAIL %s xdata got %h exp known", tag, d);
      end
      checks++;
      assert (v === 1'b1 || d === '0) else begin
         errors++;
         $error("FAIL %s gate got %h exp 0", tag, d);
      end
   endtask

   task automatic check_all(input string tag);
      logic [65:0] e;
      for (int k = 0; k < NI; k++) begin
         for (int p = 0; p < nrd(k); p++) begin
            if (lat(k)) e = {qv[k][p], qd[k][p]};
            else e = exp_rd(k, r_en[p], r_addr[p*3 +: 3]);
            chk($sformatf("%s.u%0d.p%0d", tag, k, p),
                od[k][p], ov[k][p], e);
         end
      end
   endtask

   // Check before the edge, advance the model at the edge.
   task automatic cycle(input string tag);
      logic [65:0] e;
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         for (int p = 0; p < nrd(k); p++) begin
            if (lat(k) && r_en[p]) begin
               e = exp_rd(k, r_en[p], r_addr[p*3 +: 3]);
               {qv[k][p], qd[k][p]} = e;
            end
         end
         if (flush) begin
            for (int a = 0; a < 8; a++) mv[k][a] = 1'b0;
         end
         if (w_en && int'(w_addr) < dep(k)) begin
            mm[k][w_addr] = merged(mm[k][w_addr]);
            mv[k][w_addr] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic set_wr(input logic en, input logic [2:0] a,
      input logic [4:0] m, input logic [64:0] d, input logic f);
      w_en = en; w_addr = a; w_mask = m; w_data = d; flush = f;
   endtask

   task automatic set_rd(input logic [1:0] en,
      input logic [2:0] a0, input logic [2:0] a1);
      r_en = en; r_addr = {a1, a0};
   endtask

   task automatic model_clear();
      for (int k = 0; k < NI; k++) begin
         for (int a = 0; a < 8; a++) mv[k][a] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            qd[k][p] = '0; qv[k][p] = 1'b0;
         end
      end
   endtask

   // Reset pulse between edges; outputs must clear at once.
   task automatic mid_reset(input string tag);
      set_wr(0, 0, 0, '0, 0);
      r_en = 2'b00;
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      check_all(tag);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 8; a++) mm[k][a] = '0;
      model_clear();
      reset_n = 1'b0;
      set_wr(0, 0, 0, '0, 0);
      set_rd(2'b00, 0, 0);
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: everything reads invalid after reset
      for (int a = 0; a < 5; a++) begin
         set_rd(2'b11, 3'(a), 3'(a));
         cycle("t1");
      end

      // 2: full write, read hit and an empty neighbour
      set_wr(1, 3, 5'h1f, 65'h1_0000_0000_DEAD_BEEF, 0);
      set_rd(2'b00, 0, 0);
      cycle("t2w");
      set_wr(0, 0, 0, '0, 0);
      set_rd(2'b11, 3, 2);
      cycle("t2a");
      cycle("t2b");

      // 3: only the low granule changes
      set_wr(1, 3, 5'b00001, '1, 0);
      set_rd(2'b00, 0, 0);
      cycle("t3w");
      set_wr(0, 0, 0, '0, 0);
      set_rd(2'b11, 3, 3);
      cycle("t3a");
      cycle("t3b");

      // 4: read of the entry being written
      set_wr(1, 1, 5'h1f, 65'h5A, 0);
      set_rd(2'b11, 1, 1);
      cycle("t4a");
      set_wr(0, 0, 0, '0, 0);
      cycle("t4b");

      // 5: fill, then flush together with a write
      for (int a = 0; a < 8; a++) begin
         set_wr(1, 3'(a), 5'h1f,
                65'(a + 1) * 65'h1_2345_6789_ABCD_EF01, 0);
         set_rd(2'b00, 0, 0);
         cycle("t5f");
      end
      set_wr(1, 4, 5'h1f, 65'h77, 1);
      set_rd(2'b11, 4, 0);
      cycle("t5x");
      set_wr(0, 0, 0, '0, 0);
      for (int a = 0; a < 8; a++) begin
         set_rd(2'b11, 3'(a), 3'(7 - a));
         cycle("t5r");
         cycle("t5s");
      end

      // held registered outputs drop with reset
      set_rd(2'b11, 4, 4);
      cycle("t5h");
      cycle("t5i");
      mid_reset("rst1");
      set_wr(1, 2, 5'h1f, 65'h1_2222_3333_4444_5555, 0);
      cycle("t5c");

      // 6: addresses past DEPTH on the small instances
      set_wr(1, 5, 5'h1f, 65'h55, 0);
      set_rd(2'b11, 5, 7);
      cycle("t6a");
      set_wr(1, 7, 5'h1f, 65'h99, 0);
      cycle("t6b");
      set_wr(0, 0, 0, '0, 0);
      for (int a = 0; a < 8; a++) begin
         set_rd(2'b11, 3'(a), 3'(a));
         cycle("t6r");
         cycle("t6s");
      end

      // random traffic with a reset in the middle
      for (int i = 0; i < 300; i++) begin
         if (i == 150) mid_reset("rst2");
         set_wr(1'($urandom), 3'($urandom_range(0, 7)),
                5'($urandom),
                65'({$urandom, $urandom, $urandom}),
                ($urandom_range(0, 11) == 0));
         set_rd(2'($urandom), 3'($urandom), 3'($urandom));
         cycle("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
